// File: rtl/debug_apb_regbank_pkg.sv
// Shared definitions for the APB debug register bank: transfer phase
// encodings, wait-counter width and the location of the read-only
// write-counter word.
// Optional feature macro: DEBUG_APB_PSTRB_EN (APB4 byte strobes).
package debug_apb_regbank_pkg;

  // Phase of the current APB transfer as seen by the slave
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  // Enough for WAIT_STATES up to 7
  localparam int unsigned WCNT_W = 3;

  // The write-counter word sits directly after the last RW register
  function automatic logic [31:0] wrcnt_offset(input int unsigned num_regs);
    return 32'(4 * num_regs);
  endfunction

endpackage

// File: rtl/debug_apb_wait_ctrl.sv
// APB transfer sequencer: recognises the setup phase, inserts WAIT_STATES
// access cycles with pready low, and produces the write commit strobe.
// Optional feature macro: DEBUG_APB_PSTRB_EN (not used in this file).
module debug_apb_wait_ctrl
  import debug_apb_regbank_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic psel_i,
  input  logic penable_i,
  input  logic pwrite_i,
  input  logic err_i,
  output logic setup_o,
  output logic pready_o,
  output logic commit_o
);

  localparam logic [WCNT_W-1:0] WS = WCNT_W'(WAIT_STATES);

  apb_state_e        state_q, state_d;
  apb_state_e        phase;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;

  // The setup cycle is recognised combinationally so ACCESS starts on the
  // very next edge and a zero-wait transfer takes exactly two cycles.
  assign phase = (state_q == ST_ACCESS) ? ST_ACCESS :
                 ((psel_i && !penable_i) ? ST_SETUP : ST_IDLE);

  // State register and wait counter; reset abandons any transfer in flight
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Next-state: SETUP always enters ACCESS; ACCESS counts waits, then ends
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    unique case (phase)
      ST_SETUP: begin
        state_d = ST_ACCESS;
        wcnt_d  = '0;
      end
      ST_ACCESS: begin
        if (!(psel_i && penable_i)) begin
          state_d = ST_IDLE;
        end else if (wcnt_q == WS) begin
          state_d = ST_IDLE;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: completion and a commit strobe only for error-free writes
  always_comb begin
    setup_o  = (phase == ST_SETUP);
    pready_o = (state_q == ST_ACCESS) && (wcnt_q == WS);
    commit_o = pready_o && psel_i && penable_i && pwrite_i && !err_i;
  end

endmodule

// File: rtl/debug_apb_regbank.sv
// APB debug register bank: NUM_REGS read/write debug words plus one
// read-only saturating write counter, decoded strictly at BASE_ADDR.
// Optional feature macro: DEBUG_APB_PSTRB_EN adds the pstrb byte-strobe port.
module debug_apb_regbank
  import debug_apb_regbank_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h40010000,
  parameter int unsigned NUM_REGS    = 4,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         psel,
  input  logic                         penable,
  input  logic                         pwrite,
  input  logic [31:0]                  paddr,
  input  logic [31:0]                  pwdata,
`ifdef DEBUG_APB_PSTRB_EN
  input  logic [3:0]                   pstrb,
`endif
  output logic [31:0]                  prdata,
  output logic                         pready,
  output logic                         pslverr,
  output logic [NUM_REGS*DATA_W-1:0]   debug_out,
  output logic [NUM_REGS-1:0]          debug_wr_pulse
);

  localparam int unsigned IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [31:0] CNT_OFF = wrcnt_offset(NUM_REGS);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [CNT_W-1:0]  cnt_q;
  logic [NUM_REGS-1:0] pulse_q;
  logic [IDX_W-1:0]  idx_q;
  logic              err_q;
  logic [31:0]       rdata_q;

  logic [31:0]       off;
  logic              legal, is_cnt, err_d;
  logic [IDX_W-1:0]  idx_d;
  logic [31:0]       rdata_d;
  logic              setup, commit, do_wr;
  logic [DATA_W-1:0] wmask, wdata_d;

  assign off    = paddr - BASE_ADDR;
  assign legal  = (paddr[1:0] == 2'b00) && (off <= CNT_OFF);
  assign is_cnt = (off == CNT_OFF);
  assign idx_d  = off[IDX_W+1:2];
  assign err_d  = !legal || (pwrite && is_cnt);

  // Read word for the address presented in the setup phase
  always_comb begin
    rdata_d = '0;
    if (!err_d) begin
      if (is_cnt) rdata_d = 32'(cnt_q);
      else        rdata_d = 32'(regs_q[idx_d]);
    end
  end

  debug_apb_wait_ctrl #(
    .WAIT_STATES(WAIT_STATES)
  ) u_wait_ctrl (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .psel_i   (psel),
    .penable_i(penable),
    .pwrite_i (pwrite),
    .err_i    (err_q),
    .setup_o  (setup),
    .pready_o (pready),
    .commit_o (commit)
  );

`ifdef DEBUG_APB_PSTRB_EN
  // Byte lanes beyond DATA_W are ignored; an all-zero strobe writes nothing
  always_comb begin
    wmask = '0;
    for (int b = 0; b < int'(DATA_W / 8); b++) begin
      wmask[b*8 +: 8] = {8{pstrb[b]}};
    end
  end
  assign do_wr = commit && (pstrb != 4'b0000);
`else
  assign wmask = '1;
  assign do_wr = commit;
`endif

  assign wdata_d = (regs_q[idx_q] & ~wmask) | (pwdata[DATA_W-1:0] & wmask);

  // Latch decode result and read data at the end of the setup phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else if (setup) begin
      idx_q   <= idx_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Register array update on an accepted write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
    end else if (do_wr) begin
      regs_q[idx_q] <= wdata_d;
    end
  end

  // One-cycle write pulse and saturating write counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_q <= '0;
      cnt_q   <= '0;
    end else begin
      pulse_q <= '0;
      if (do_wr) begin
        pulse_q[idx_q] <= 1'b1;
        if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  for (genvar i = 0; i < int'(NUM_REGS); i++) begin : g_dbg
    assign debug_out[i*DATA_W +: DATA_W] = regs_q[i];
  end

  assign debug_wr_pulse = pulse_q;
  assign prdata         = pready ? rdata_q : 32'h0;
  assign pslverr        = pready && err_q;

endmodule

// File: tb/tb_debug_apb_regbank.sv
// Self-checking bench for debug_apb_regbank: three instances (default,
// WAIT_STATES=3, CNT_W=2/WAIT_STATES=1) on one shared APB bus with per-slave psel.
// Optional feature macro: DEBUG_APB_PSTRB_EN enables the byte-strobe sequence.
module tb_debug_apb_regbank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [2:0]  psel_v;
  logic        penable, pwrite;
  logic [31:0] paddr, pwdata;
`ifdef DEBUG_APB_PSTRB_EN
  logic [3:0]  pstrb;
`endif
  logic [31:0]  prdata_a [3];
  logic [2:0]   pready_v, pslverr_v;
  logic [127:0] dbg_a [3];
  logic [3:0]   pls_a [3];

  debug_apb_regbank u_dut0 (
    .clk(clk), .rst_n(rst_n), .psel(psel_v[0]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata),
`ifdef DEBUG_APB_PSTRB_EN
    .pstrb(pstrb),
`endif
    .prdata(prdata_a[0]), .pready(pready_v[0]), .pslverr(pslverr_v[0]),
    .debug_out(dbg_a[0]), .debug_wr_pulse(pls_a[0]));

  debug_apb_regbank #(.WAIT_STATES(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .psel(psel_v[1]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata),
`ifdef DEBUG_APB_PSTRB_EN
    .pstrb(pstrb),
`endif
    .prdata(prdata_a[1]), .pready(pready_v[1]), .pslverr(pslverr_v[1]),
    .debug_out(dbg_a[1]), .debug_wr_pulse(pls_a[1]));

  debug_apb_regbank #(.WAIT_STATES(1), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .psel(psel_v[2]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata),
`ifdef DEBUG_APB_PSTRB_EN
    .pstrb(pstrb),
`endif
    .prdata(prdata_a[2]), .pready(pready_v[2]), .pslverr(pslverr_v[2]),
    .debug_out(dbg_a[2]), .debug_wr_pulse(pls_a[2]));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
  } vec_t;

  typedef struct {
    bit          rd;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  function automatic vec_t mk(bit wr, logic [31:0] addr, logic [31:0] wdata,
                              logic [31:0] rdata, bit err);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.err = err;
    return v;
  endfunction

  exp_t sb_q[$];
  exp_t e_mon;
  bit   mon_en = 1'b0;

  // Scoreboard monitor for slave 0: pops one expectation per completed transfer
  always @(negedge clk) begin
    if (mon_en && psel_v[0] && penable && pready_v[0]) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_underflow: got completion expected none");
      end else begin
        e_mon = sb_q.pop_front();
        check("sb_pslverr", 128'(pslverr_v[0]), 128'(e_mon.err));
        if (e_mon.rd) check("sb_prdata", 128'(prdata_a[0]), 128'(e_mon.rdata));
      end
    end
  end

  // One complete APB transfer to slave d; returns data, error and wait count
  task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rdata,
                      output logic err, output int waits);
    @(posedge clk); #1;
    psel_v  = 3'(1 << d);
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wdata;
    @(posedge clk); #1;
    penable = 1'b1;
    waits   = 0;
    rdata   = 'x;
    err     = 1'bx;
    forever begin
      @(negedge clk);
      if (pready_v[d]) begin
        rdata = prdata_a[d];
        err   = pslverr_v[d];
        break;
      end
      waits++;
      if (waits > 40) begin
        n_tests++;
        n_fail++;
        $display("FAIL xfer_timeout: got no pready expected pready within 40 cycles");
        break;
      end
    end
    @(posedge clk); #1;
    psel_v  = '0;
    penable = 1'b0;
  endtask

  vec_t        tbl [21];
  logic [31:0] rd;
  logic        er;
  int          w;

  initial begin
    rst_n   = 1'b0;
    psel_v  = '0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
`ifdef DEBUG_APB_PSTRB_EN
    pstrb   = 4'hF;
`endif
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check("rst_pready",  128'(pready_v[k]),  128'(0));
      check("rst_pslverr", 128'(pslverr_v[k]), 128'(0));
      check("rst_prdata",  128'(prdata_a[k]),  128'(0));
      check("rst_dbg",     dbg_a[k],           128'(0));
      check("rst_pulse",   128'(pls_a[k]),     128'(0));
    end
    rst_n = 1'b1;

    // Slave 0 vectors: reads, a write, strict decode errors, counter readback
    tbl[0]  = mk(0, 32'h40010000, 0, 32'h0, 0);
    tbl[1]  = mk(0, 32'h40010004, 0, 32'h0, 0);
    tbl[2]  = mk(0, 32'h40010008, 0, 32'h0, 0);
    tbl[3]  = mk(0, 32'h4001000C, 0, 32'h0, 0);
    tbl[4]  = mk(0, 32'h40010010, 0, 32'h0, 0);
    tbl[5]  = mk(1, 32'h40010004, 32'hDEADBEEF, 0, 0);
    tbl[6]  = mk(0, 32'h40010004, 0, 32'hDEADBEEF, 0);
    tbl[7]  = mk(0, 32'h40010010, 0, 32'h1, 0);
    tbl[8]  = mk(1, 32'h40010002, 32'h11111111, 0, 1);
    tbl[9]  = mk(1, 32'h40010014, 32'h22222222, 0, 1);
    tbl[10] = mk(1, 32'h40010010, 32'h33333333, 0, 1);
    tbl[11] = mk(0, 32'h40010010, 0, 32'h1, 0);
    tbl[12] = mk(0, 32'h40010014, 0, 32'h0, 1);
    tbl[13] = mk(1, 32'h40010000, 32'h12345678, 0, 0);
    tbl[14] = mk(1, 32'h4001000C, 32'h0000FFFF, 0, 0);
    tbl[15] = mk(0, 32'h40010000, 0, 32'h12345678, 0);
    tbl[16] = mk(0, 32'h4001000C, 0, 32'h0000FFFF, 0);
    tbl[17] = mk(0, 32'h40010010, 0, 32'h3, 0);
    tbl[18] = mk(0, 32'h3FFF0000, 0, 32'h0, 1);
    tbl[19] = mk(1, 32'h40010008, 32'h0, 0, 0);
    tbl[20] = mk(0, 32'h40010010, 0, 32'h4, 0);

    mon_en = 1'b1;
    for (int i = 0; i < 21; i++) begin
      sb_q.push_back('{rd: !tbl[i].wr, rdata: tbl[i].rdata, err: tbl[i].err});
      xfer(0, tbl[i].wr, tbl[i].addr, tbl[i].wdata, rd, er, w);
      check("tbl_waits", 128'(w), 128'(0));
    end
    mon_en = 1'b0;
    check("sb_drained", 128'(sb_q.size()), 128'(0));
    check("tbl_debug_out", dbg_a[0], {32'h0000FFFF, 32'h0, 32'hDEADBEEF, 32'h12345678});

    // Write pulse lasts exactly one cycle after the update
    xfer(0, 1, 32'h40010004, 32'hCAFEF00D, rd, er, w);
    check("pulse_on",  128'(pls_a[0]), 128'(4'b0010));
    check("dbg_reg1",  128'(dbg_a[0][63:32]), 128'(32'hCAFEF00D));
    @(posedge clk); #1;
    check("pulse_off", 128'(pls_a[0]), 128'(0));

    // Wait states on slave 1
    xfer(1, 1, 32'h40010000, 32'hA5A50001, rd, er, w);
    check("ws3_wr_waits", 128'(w), 128'(3));
    check("ws3_wr_err",   128'(er), 128'(0));
    xfer(1, 0, 32'h40010000, 0, rd, er, w);
    check("ws3_rd_waits", 128'(w), 128'(3));
    check("ws3_rd_data",  128'(rd), 128'(32'hA5A50001));

    // psel dropped mid-wait: no update, no count
    @(posedge clk); #1;
    psel_v = 3'b010; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h40010004; pwdata = 32'h00000055;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    check("abort_pready_low", 128'(pready_v[1]), 128'(0));
    @(posedge clk); #1;
    psel_v = '0; penable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("abort_pulse", 128'(pls_a[1]), 128'(0));
    check("abort_dbg",   128'(dbg_a[1][63:32]), 128'(0));
    xfer(1, 0, 32'h40010010, 0, rd, er, w);
    check("abort_cnt", 128'(rd), 128'(1));

    // Saturating 2-bit counter on slave 2
    for (int i = 0; i < 5; i++) begin
      xfer(2, 1, 32'h40010000 + 32'(4 * (i % 4)), 32'(i + 1), rd, er, w);
      check("sat_wr_waits", 128'(w), 128'(1));
    end
    xfer(2, 0, 32'h40010010, 0, rd, er, w);
    check("sat_cnt", 128'(rd), 128'(3));
    xfer(2, 0, 32'h40010000, 0, rd, er, w);
    check("sat_reg0", 128'(rd), 128'(5));

`ifdef DEBUG_APB_PSTRB_EN
    // Byte strobes on slave 0 register 2
    xfer(0, 1, 32'h40010008, 32'h11223344, rd, er, w);
    pstrb = 4'b0101;
    xfer(0, 1, 32'h40010008, 32'hAABBCCDD, rd, er, w);
    pstrb = 4'b0000;
    xfer(0, 1, 32'h40010008, 32'hFFFFFFFF, rd, er, w);
    check("strb0_err",   128'(er), 128'(0));
    check("strb0_pulse", 128'(pls_a[0]), 128'(0));
    pstrb = 4'hF;
    xfer(0, 0, 32'h40010008, 0, rd, er, w);
    check("strb_merge", 128'(rd), 128'(32'h11BB33DD));
    xfer(0, 0, 32'h40010010, 0, rd, er, w);
    check("strb_cnt", 128'(rd), 128'(7));
`endif

    // Asynchronous reset while slave 1 sits in a wait state
    @(posedge clk); #1;
    psel_v = 3'b010; penable = 1'b0; pwrite = 1'b0; paddr = 32'h40010000;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_pready",  128'(pready_v),  128'(0));
    check("arst_pslverr", 128'(pslverr_v), 128'(0));
    check("arst_prdata",  128'(prdata_a[1]), 128'(0));
    check("arst_dbg0",    dbg_a[0], 128'(0));
    check("arst_dbg1",    dbg_a[1], 128'(0));
    check("arst_dbg2",    dbg_a[2], 128'(0));
    psel_v = '0; penable = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    xfer(1, 0, 32'h40010000, 0, rd, er, w);
    check("post_rst_waits", 128'(w), 128'(3));
    check("post_rst_reg0",  128'(rd), 128'(0));
    xfer(1, 0, 32'h40010010, 0, rd, er, w);
    check("post_rst_cnt",   128'(rd), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
